// File: rtl/tc_mod7_accumulator.sv
// Frame-based modulo-7 residue accumulator with a thermometer-coded result.
// Optional range check on 3'b111 operands enabled by TC_ACC_RANGE_CHK_EN.
module tc_mod7_accumulator #(
    parameter int MAX_LEN = 16,
    parameter int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [5:0]    out_tc,
    output logic [LW-1:0] out_len,
    output logic          out_err
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [2:0]    acc_r;
    logic [LW-1:0] cnt_r;
    logic [5:0]    out_tc_r;
    logic [LW-1:0] out_len_r;
    logic          accept_s;
    logic          frame_end_s;
    logic [LW-1:0] cnt_inc_s;
    logic [2:0]    operand_s;
    logic [2:0]    acc_nxt_s;

    function automatic logic [2:0] mod7_add(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 4'd7) begin
            sum = sum - 4'd7;
        end else begin
            sum = sum;
        end
        return sum[2:0];
    endfunction

    function automatic logic [5:0] to_thermo(input logic [2:0] k);
        logic [5:0] code;
        case (k)
            3'd0:    code = 6'b000000;
            3'd1:    code = 6'b000001;
            3'd2:    code = 6'b000011;
            3'd3:    code = 6'b000111;
            3'd4:    code = 6'b001111;
            3'd5:    code = 6'b011111;
            3'd6:    code = 6'b111111;
            default: code = 6'b000000;
        endcase
        return code;
    endfunction

    // 3'b111 is 7 mod 7, so it always contributes zero to the sum
    assign operand_s   = (in_data == 3'b111) ? 3'd0 : in_data;
    assign accept_s    = in_valid && (state_r == ACCUM);
    assign cnt_inc_s   = cnt_r + {{(LW-1){1'b0}}, 1'b1};
    assign frame_end_s = accept_s && (in_last || (cnt_inc_s == LW'(MAX_LEN)));
    assign acc_nxt_s   = mod7_add(acc_r, operand_s);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ACCUM;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ACCUM: begin
                if (frame_end_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt_s = ACCUM;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = ACCUM;
        endcase
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state_r)
            ACCUM: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            HOLD: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
        endcase
    end

    // Accumulator, beat counter and frame result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r     <= 3'd0;
            cnt_r     <= '0;
            out_tc_r  <= 6'b000000;
            out_len_r <= '0;
        end else if (frame_end_s) begin
            acc_r     <= 3'd0;
            cnt_r     <= '0;
            out_tc_r  <= to_thermo(acc_nxt_s);
            out_len_r <= cnt_inc_s;
        end else if (accept_s) begin
            acc_r     <= acc_nxt_s;
            cnt_r     <= cnt_inc_s;
        end else begin
            acc_r     <= acc_r;
            cnt_r     <= cnt_r;
        end
    end

    assign out_tc  = out_tc_r;
    assign out_len = out_len_r;

`ifdef TC_ACC_RANGE_CHK_EN
    logic err_r;
    logic out_err_r;
    logic err_nxt_s;

    assign err_nxt_s = err_r || (in_data == 3'b111);

    // Sticky illegal-operand flag, reported with the frame result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_r     <= 1'b0;
            out_err_r <= 1'b0;
        end else if (frame_end_s) begin
            err_r     <= 1'b0;
            out_err_r <= err_nxt_s;
        end else if (accept_s) begin
            err_r     <= err_nxt_s;
        end else begin
            err_r     <= err_r;
        end
    end

    assign out_err = out_err_r;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_tc_mod7_accumulator.sv
// Self-checking bench for tc_mod7_accumulator (MAX_LEN=4): directed scenarios
// plus randomized traffic checked against a frame-level reference model.
module tb_tc_mod7_accumulator;

    localparam int ML  = 4;
    localparam int LWT = $clog2(ML + 1);

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     in_data;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [5:0]     out_tc;
    logic [LWT-1:0] out_len;
    logic           out_err;

    int checks = 0;
    int errors = 0;

    tc_mod7_accumulator #(.MAX_LEN(ML)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tc    (out_tc),
        .out_len   (out_len),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef TC_ACC_RANGE_CHK_EN
    localparam logic ERR_ON_ILLEGAL = 1'b1;
`else
    localparam logic ERR_ON_ILLEGAL = 1'b0;
`endif

    function automatic logic [5:0] thermo(input int k);
        return 6'((1 << k) - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until accepted (bounded)
    task automatic send_beat(input logic [2:0] d, input logic l);
        logic rdy;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int n = 0; n < 20; n++) begin
            rdy = in_ready;
            tick();
            if (rdy) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL send_beat_timeout: in_ready=%0b required 1 within 20 cycles", in_ready);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = 3'd2; in_last = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_tc !== 6'b000000 || out_len !== 3'd0 || out_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: rdy=%0b vld=%0b tc=%b len=%0d err=%0b required 1 0 000000 0 0",
                         in_ready, out_valid, out_tc, out_len, out_err);
            end
        end
        rst_n = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_tc !== 6'b000011 || out_len !== 3'd1) begin
            errors++;
            $display("FAIL reset_first_beat: vld=%0b tc=%b len=%0d required 1 000011 1", out_valid, out_tc, out_len);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_return_accum: vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        send_beat(3'd5, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_mid_frame: vld=%0b required 0", out_valid);
        end
        send_beat(3'd4, 1'b0);
        send_beat(3'd6, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_tc !== 6'b000001 || out_len !== 3'd3 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL wrap_result: vld=%0b tc=%b len=%0d rdy=%0b required 1 000001 3 0",
                     out_valid, out_tc, out_len, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wrap_one_cycle: vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_beat(3'd3, 1'b0);
        send_beat(3'd3, 1'b1);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_tc !== 6'b111111 || out_len !== 3'd2 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold: vld=%0b tc=%b len=%0d rdy=%0b required 1 111111 2 0",
                         out_valid, out_tc, out_len, in_ready);
            end
            in_valid = 1'b1; in_data = 3'd1; in_last = 1'b1;
            tick();
        end
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_tc !== 6'b111111) begin
            errors++;
            $display("FAIL backpressure_still_held: vld=%0b tc=%b required 1 111111", out_valid, out_tc);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
        end
        send_beat(3'd2, 1'b1);
        checks++;
        if (out_tc !== 6'b000011 || out_len !== 3'd1) begin
            errors++;
            $display("FAIL backpressure_no_leak: tc=%b len=%0d required 000011 1", out_tc, out_len);
        end
        tick();
    endtask

    task automatic test_max_len();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(3'd2, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_tc !== 6'b000001 || out_len !== 3'd4) begin
            errors++;
            $display("FAIL maxlen_first: vld=%0b tc=%b len=%0d required 1 000001 4", out_valid, out_tc, out_len);
        end
        send_beat(3'd2, 1'b0);
        send_beat(3'd2, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_tc !== 6'b001111 || out_len !== 3'd2) begin
            errors++;
            $display("FAIL maxlen_second: vld=%0b tc=%b len=%0d required 1 001111 2", out_valid, out_tc, out_len);
        end
        tick();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        send_beat(3'b111, 1'b0);
        send_beat(3'd2, 1'b1);
        checks++;
        if (out_tc !== 6'b000011 || out_err !== ERR_ON_ILLEGAL) begin
            errors++;
            $display("FAIL illegal_operand: tc=%b err=%0b required 000011 %0b", out_tc, out_err, ERR_ON_ILLEGAL);
        end
        tick();
        send_beat(3'd1, 1'b1);
        checks++;
        if (out_tc !== 6'b000001 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_err_clears: tc=%b err=%0b required 000001 0", out_tc, out_err);
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b1;
        send_beat(3'd4, 1'b0);
        send_beat(3'd4, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_tc !== 6'b000000 || out_len !== 3'd0) begin
            errors++;
            $display("FAIL midreset_state: vld=%0b tc=%b len=%0d required 0 000000 0", out_valid, out_tc, out_len);
        end
        send_beat(3'd1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_tc !== 6'b000001 || out_len !== 3'd1) begin
            errors++;
            $display("FAIL midreset_frame: vld=%0b tc=%b len=%0d required 1 000001 1", out_valid, out_tc, out_len);
        end
        tick();
    endtask

    // Random traffic against a frame-level model: operands collected per frame,
    // result computed with plain modular arithmetic when the frame closes.
    task automatic test_random();
        int            cur[$];
        logic [5:0]    exp_tc[$];
        int            exp_len[$];
        logic          exp_err[$];
        logic          rdy, vld, ordy, acc;
        int            sum;
        logic          bad;
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 3'($urandom_range(0, 7));
            in_last   = ($urandom_range(0, 4) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rdy  = in_ready;
            vld  = out_valid;
            ordy = out_ready;
            tick();
            if (vld && ordy && exp_tc.size() != 0) begin
                void'(exp_tc.pop_front());
                void'(exp_len.pop_front());
                void'(exp_err.pop_front());
            end
            acc = in_valid && rdy;
            if (acc) begin
                cur.push_back(int'(in_data));
                if (in_last || cur.size() == ML) begin
                    sum = 0;
                    bad = 1'b0;
                    foreach (cur[i]) begin
                        if (cur[i] == 7) bad = ERR_ON_ILLEGAL;
                        else sum += cur[i];
                    end
                    exp_tc.push_back(thermo(sum % 7));
                    exp_len.push_back(cur.size());
                    exp_err.push_back(bad);
                    cur.delete();
                end
            end
            checks++;
            if (out_valid !== (exp_tc.size() != 0) || in_ready !== !out_valid) begin
                errors++;
                $display("FAIL random_handshake cycle %0d: vld=%0b rdy=%0b required vld=%0b rdy=%0b",
                         c, out_valid, in_ready, exp_tc.size() != 0, exp_tc.size() == 0);
            end else if (out_valid) begin
                checks++;
                if (out_tc !== exp_tc[0] || out_len !== LWT'(exp_len[0]) || out_err !== exp_err[0]) begin
                    errors++;
                    $display("FAIL random_result cycle %0d: tc=%b len=%0d err=%0b required %b %0d %0b",
                             c, out_tc, out_len, out_err, exp_tc[0], exp_len[0], exp_err[0]);
                end
            end
            checks++;
            if ((({1'b0, out_tc} + 7'd1) & {1'b0, out_tc}) != 7'd0) begin
                errors++;
                $display("FAIL random_legal_code cycle %0d: tc=%b required a thermometer code", c, out_tc);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 3'd0; in_last = 1'b0; out_ready = 1'b0;
        test_reset();
        test_wrap();
        test_backpressure();
        test_max_len();
        test_illegal();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tc_mod7_accumulator.md
# tc_mod7_accumulator

Frame-based modulo-7 residue accumulator for the RNS datapath. It accepts a stream of 3-bit binary residues over a valid/ready handshake and sums each frame modulo 7. It emits the frame result as a 6-bit thermometer code, which feeds the downstream thermometer-to-binary converter directly. Result encoding: value k (0..6) drives the low k bits high, e.g. 3 = 6'b000111 and 0 = 6'b000000.

## Interface
- MAX_LEN, 16: maximum operands per frame; legal range 2..255.
- LW, $clog2(MAX_LEN+1): width of out_len (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  3  binary residue, legal 0..6.
- in_last  in  1  final operand of the frame.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts the result.
- out_tc  out  6  frame sum mod 7, thermometer code [6:1] (bit 1 = LSB).
- out_len  out  LW  operands accepted in the frame.
- out_err  out  1  frame contained an illegal operand (see Configuration).

## Operation
- **States:** ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
- **Internal registers:** acc (mod-7 value, 0..6), cnt (0..MAX_LEN), err_s.
- **ACCUM, accepted beat** (in_valid & in_ready):
  - acc ← (acc + v) mod 7, where v = in_data, except 3'b111 gives v = 0.
  - cnt ← cnt+1.
- **End of frame:** the beat is the last one if in_last=1 or cnt+1 == MAX_LEN. MAX_LEN forces termination; any in_last on the next beat belongs to the next frame.
- **On the last beat, next cycle:**
  - state → HOLD.
  - out_tc ← thermometer code of the updated acc.
  - out_len ← cnt+1.
  - out_err ← err_s, including the current beat.
  - acc, cnt and err_s clear to 0.
- **HOLD:**
  - out_tc, out_len and out_err are held stable until out_valid & out_ready.
  - After that handshake, state → ACCUM in the next cycle.
  - in_valid is ignored.
- **in_valid=0 in ACCUM:** no state change; gaps within a frame are allowed.
- **Arithmetic:** the sum of two values 0..6 is at most 12; subtract 7 when the sum ≥ 7. out_tc must only ever hold one of the 7 legal codes.
- **Illegal codes:** out_tc never carries a non-thermometer code. The downstream converter maps illegal codes to 0, so any such code here is a bug.

## Timing
- **Reset:** when rst_n=0 at a clock edge:
  - state = ACCUM; in_ready=1; out_valid=0.
  - out_tc=6'b000000, out_len=0, out_err=0.
  - acc, cnt and err_s = 0.
- **Reset mid-frame or in HOLD:** the partial frame or pending result is discarded, with no output.
- **Latency:** out_valid rises exactly 1 cycle after the last beat is accepted.
- **Throughput:** one operand per cycle within a frame. There is at least one dead input cycle per frame (the HOLD cycle). With out_ready tied 1, a new frame starts accepting 2 cycles after the previous last beat.
- **Registered outputs:** in_ready and out_valid are registered state decodes with no combinational path from in_valid. out_ready is the only input that affects the next state while in HOLD.
- **Single-operand frame** (in_last on the first beat): out_tc is that operand's value and out_len=1.

## Configuration
- **Macro:** TC_ACC_RANGE_CHK_EN.
- **Defined:**
  - An accepted beat with in_data=3'b111 sets err_s; that operand contributes 0.
  - out_err reports err_s with the frame result.
  - err_s clears at frame end and on reset.
- **Undefined:**
  - 3'b111 is silently treated as 0 (7 mod 7), with identical sum behaviour.
  - out_err is tied to 0 and err_s is not built.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles with in_valid=1 → in_ready=1, out_valid=0, out_tc=000000, out_len=0 throughout. Release rst_n; the first beat is accepted.
- **Wrap frame:** operands 5, 4, 6 (last on 6), out_ready=1. Required response:
  - Sum 15 mod 7 = 1, so out_tc=6'b000001 and out_len=3.
  - out_valid rises 1 cycle after the last beat and is high for 1 cycle.
- **Backpressure:** frame 3, 3 with out_ready=0 for 5 cycles:
  - out_tc=6'b111111 and out_len=2, held stable.
  - in_ready=0 during HOLD, and beats offered then are not accepted.
  - out_ready=1 → ACCUM next cycle.
- **MAX_LEN termination** (MAX_LEN=4): 6 operands of 2, in_last only on the 6th:
  - First result: 8 mod 7 = 1, so out_tc=000001 and out_len=4.
  - Second result: 4, so out_tc=001111 and out_len=2.
- **Illegal operand:** frame 3'b111, 2 (last):
  - With TC_ACC_RANGE_CHK_EN: out_tc=000011 and out_err=1. The next frame, 1 (last), gives out_err=0.
  - Without the macro: out_tc=000011 and out_err=0.
- **Reset mid-frame:** accept 4, 4, then pulse rst_n=0 for 1 cycle, then frame 1 (last) → out_tc=000001, out_len=1, with no stale result emitted.
